instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Producer end of the dual-issue instruction FIFO.
- Generates the fetch PC, issues 64-bit (two-instruction) requests to the instruction cache over an addr/data handshake, and pushes the returned instructions plus their PCs into the FIFO write port (write_en1/2, write_data1/2, write_address1/2).
- Handles FIFO backpressure, odd-word alignment, and branch/exception redirects, including discarding an in-flight response.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
- redirect_valid  in  1  branch/exception redirect request.
- redirect_pc  in  32  new fetch target, word aligned.
- fifo_full  in  1  FIFO full flag (count >= 14).
- inst_req  out  1  cache request valid.
- inst_addr  out  32  request address, 8-byte aligned ({req_pc[31:3],3'b0}).
- inst_addr_ok  in  1  cache accepted request this cycle.
- inst_rdata  in  64  [31:0]=word at addr, [63:32]=word at addr+4.
- inst_data_ok  in  1  response valid this cycle.
- fifo_flush  out  1  clears FIFO contents; drives FIFO reset/flush.
- write_en1, write_en2  out  1 each  FIFO write enables.
- write_data1, write_data2  out  32 each  instructions.
- write_address1, write_address2  out  32 each  instruction PCs.

Behaviour:
- Reset (rst==0 at edge):
  - pc=RESET_PC, state=IDLE.
  - All outputs 0 except fifo_flush=1 while rst==0.
- States:
  - IDLE: if !fifo_full and no redirect, assert inst_req with req_pc=pc; go REQ.
  - REQ: inst_req=1; inst_addr held stable until inst_addr_ok.
    - On inst_addr_ok: go WAIT, or DISCARD if a redirect was seen while in REQ.
  - WAIT: wait for inst_data_ok. On data_ok with no redirect the same cycle:
    - if req_pc[2]==0: write_en1=write_en2=1; data1=rdata[31:0], addr1=req_pc; data2=rdata[63:32], addr2=req_pc+4; pc<=req_pc+8.
    - if req_pc[2]==1: write_en1 only; data1=rdata[63:32], addr1=req_pc; pc<=req_pc+4.
    - Next state: IDLE.
  - DISCARD: on inst_data_ok, drop the data (no write) and go IDLE.
- FIFO write timing: writes are combinational in the data_ok cycle (zero added latency).
  - write_en2 never asserts without write_en1.
  - Unused data/address outputs are 0.
- Backpressure: a new request issues only when fifo_full==0.
  - At most one request is outstanding, so count <= 13 + 2 never overflows the 16-entry FIFO.
- Redirect (any state, takes priority over normal pc advance):
  - pc<=redirect_pc.
  - fifo_flush=1 that cycle (combinational); write_en1/2 forced 0 that cycle.
  - IDLE: stays IDLE; the next request uses the new pc.
  - REQ without addr_ok: request stays asserted with the old address; a discard flag is set.
  - REQ with addr_ok, or WAIT: go DISCARD. If data_ok arrives in the same cycle, that response is dropped and the FSM goes IDLE.
  - DISCARD: the later of two redirects wins pc; stays DISCARD.
- PC arithmetic is 32-bit, wrapping modulo 2^32. No misalignment check; redirect_pc[1:0] is ignored (treated as 0).

Decomposition:
- Shared package (cpu_defs): fetch_state_t enum {IDLE, REQ, WAIT, DISCARD}; RESET_PC constant; instruction width (32) and fetch width (64) constants.
- Sub-module: fetch_pc_gen, holding the pc register, next-pc mux (redirect / +8 / +4) and reset vector.
- The FSM and FIFO-write logic stay in the top module.

Test Plan:
- Reset then release; cache grants addr_ok immediately, data_ok 1 cycle later -> inst_addr=0xBFC00000; write_en1/2=1 with addr1=0xBFC00000, addr2=0xBFC00004; next inst_addr=0xBFC00008.
- Redirect to 0x80000004 while IDLE -> fifo_flush=1 for 1 cycle; next inst_addr=0x80000000; on data_ok only write_en1, data1=rdata[63:32], addr1=0x80000004; next inst_addr=0x80000008.
- Hold fifo_full=1 for 5 cycles -> inst_req stays 0; on deassert, request issues the next cycle with the unchanged pc.
- Redirect to 0x80001000 in WAIT, data_ok 3 cycles later -> no write_en; the following request has inst_addr=0x80001000.
- Redirect and data_ok in the same cycle -> write_en1/2=0, fifo_flush=1, next request at redirect_pc.
- Drive rst=0 mid-WAIT -> next cycle state IDLE, pc=0xBFC00000, all write enables 0; a late data_ok is ignored.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch definitions: FSM states, reset vector, widths.
// Also the FIFO write-port bundle used by the fetch unit.
package instruction_fetch_unit_pkg;

  localparam int INST_W  = 32;
  localparam int FETCH_W = 64;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic              en;
    logic [INST_W-1:0] data;
    logic [31:0]       addr;
  } fifo_wr_t;

  function automatic logic [31:0] align8(
    input logic [31:0] a
  );
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: icache addr/data handshake plus the
// dual-issue FIFO write port and its full/flush flags.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic               inst_req;
  logic [31:0]        inst_addr;
  logic               inst_addr_ok;
  logic [FETCH_W-1:0] inst_rdata;
  logic               inst_data_ok;

  logic               fifo_full;
  logic               fifo_flush;

  logic               write_en1;
  logic               write_en2;
  logic [INST_W-1:0]  write_data1;
  logic [INST_W-1:0]  write_data2;
  logic [31:0]        write_address1;
  logic [31:0]        write_address2;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_rdata,
    input  inst_data_ok,
    input  fifo_full,
    output fifo_flush,
    output write_en1,
    output write_en2,
    output write_data1,
    output write_data2,
    output write_address1,
    output write_address2
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_rdata,
    output inst_data_ok,
    output fifo_full,
    input  fifo_flush,
    input  write_en1,
    input  write_en2,
    input  write_data1,
    input  write_data2,
    input  write_address1,
    input  write_address2
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: reset vector, redirect target or
// sequential advance by one (+4) or two (+8) words.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC =
    instruction_fetch_unit_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        adv8,
  input  logic        adv4,
  output logic [31:0] pc
);

  logic [31:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      redirect_valid:
        pc_nxt = {redirect_pc[31:2], 2'b00};
      adv8:
        pc_nxt = pc + 32'd8;
      adv4:
        pc_nxt = pc + 32'd4;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM: one outstanding icache request, pushes the
// returned words into the instruction FIFO write port.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC =
    instruction_fetch_unit_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  instruction_fetch_unit_if.master bus
);
  import instruction_fetch_unit_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        discard;
  logic        discard_nxt;

  logic issue;
  logic accept;
  logic resp;
  logic deliver;
  logic adv8;
  logic adv4;

  fifo_wr_t wr1;
  fifo_wr_t wr2;

  assign issue   = (state == IDLE) &&
                   !bus.fifo_full &&
                   !redirect_valid;
  assign accept  = (state == REQ) && bus.inst_addr_ok;
  assign resp    = bus.inst_data_ok;
  assign deliver = (state == WAIT) && resp &&
                   !redirect_valid;
  assign adv8    = deliver && !req_pc[2];
  assign adv4    = deliver && req_pc[2];

  fetch_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .adv8           (adv8),
    .adv4           (adv4),
    .pc             (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_pc freezes the request address even if pc is redirected
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_pc  <= RESET_PC;
      discard <= 1'b0;
    end else begin
      if (issue) begin
        req_pc <= pc;
      end
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          discard_nxt = 1'b0;
          state_nxt   = (discard || redirect_valid) ?
                        DISCARD : WAIT;
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (resp) begin
          state_nxt = IDLE;
        end else if (redirect_valid) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // odd-word requests only keep the upper half of the line
  always_comb begin
    wr1 = '0;
    wr2 = '0;
    if (deliver && rst) begin
      wr1.en   = 1'b1;
      wr1.addr = req_pc;
      if (req_pc[2]) begin
        wr1.data = bus.inst_rdata[63:32];
      end else begin
        wr1.data = bus.inst_rdata[31:0];
        wr2.en   = 1'b1;
        wr2.data = bus.inst_rdata[63:32];
        wr2.addr = req_pc + 32'd4;
      end
    end
  end

  assign bus.inst_req       = rst && (state == REQ);
  assign bus.inst_addr      = bus.inst_req ?
                              align8(req_pc) : '0;
  assign bus.fifo_flush     = !rst || redirect_valid;
  assign bus.write_en1      = wr1.en;
  assign bus.write_en2      = wr2.en;
  assign bus.write_data1    = wr1.data;
  assign bus.write_data2    = wr2.data;
  assign bus.write_address1 = wr1.addr;
  assign bus.write_address2 = wr2.addr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a
// randomized icache/FIFO environment with a stream-level model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_A5A5;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    redirect_valid   = 1'b0;
  endtask

  // accept the current request, then present the response
  task automatic grant(input logic [63:0] rd);
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.fifo_full = 1'b0;
    redirect_pc = '0;
    idle_in();
    @(negedge clk);
    cyc();
    #1;
    checks++; if (bus.fifo_flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", bus.fifo_flush); end
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.inst_req); end
    checks++; if (bus.write_en1 !== 1'b0 || bus.write_en2 !== 1'b0) begin errors++; $display("FAIL rst_wen got %b%b want 00", bus.write_en1, bus.write_en2); end
    checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.inst_addr); end
    rst = 1'b1;
    #1;
    checks++; if (bus.fifo_flush !== 1'b0) begin errors++; $display("FAIL rel_flush got %b want 0", bus.fifo_flush); end
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rel_req got %b want 0", bus.inst_req); end
    cyc();
  endtask

  task automatic test_basic();
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL basic_req got %b %h want 1 bfc00000", bus.inst_req, bus.inst_addr); end
    grant(64'h1111_2222_3333_4444);
    #1;
    checks++; if (bus.write_en1 !== 1'b1 || bus.write_en2 !== 1'b1) begin errors++; $display("FAIL basic_wen got %b%b want 11", bus.write_en1, bus.write_en2); end
    checks++; if (bus.write_address1 !== 32'hBFC0_0000 || bus.write_data1 !== 32'h3333_4444) begin errors++; $display("FAIL basic_w1 got %h/%h want bfc00000/33334444", bus.write_address1, bus.write_data1); end
    checks++; if (bus.write_address2 !== 32'hBFC0_0004 || bus.write_data2 !== 32'h1111_2222) begin errors++; $display("FAIL basic_w2 got %h/%h want bfc00004/11112222", bus.write_address2, bus.write_data2); end
    cyc();
    idle_in();
    #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", bus.inst_req); end
    cyc();
    #1;
    checks++; if (bus.inst_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL basic_next got %h want bfc00008", bus.inst_addr); end
    grant(64'h5);
    #1;
    checks++; if (bus.write_address1 !== 32'hBFC0_0008) begin errors++; $display("FAIL basic_w3 got %h want bfc00008", bus.write_address1); end
    cyc();
    idle_in();
  endtask

  task automatic test_redirect_idle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0004;
    #1;
    checks++; if (bus.fifo_flush !== 1'b1 || bus.inst_req !== 1'b0) begin errors++; $display("FAIL ri_flush got %b/%b want 1/0", bus.fifo_flush, bus.inst_req); end
    cyc();
    redirect_valid = 1'b0;
    #1;
    checks++; if (bus.fifo_flush !== 1'b0 || bus.inst_req !== 1'b0) begin errors++; $display("FAIL ri_after got %b/%b want 0/0", bus.fifo_flush, bus.inst_req); end
    cyc();
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0000) begin errors++; $display("FAIL ri_addr got %b %h want 1 80000000", bus.inst_req, bus.inst_addr); end
    grant(64'hAAAA_0001_BBBB_0002);
    #1;
    checks++; if (bus.write_en1 !== 1'b1 || bus.write_en2 !== 1'b0) begin errors++; $display("FAIL ri_wen got %b%b want 10", bus.write_en1, bus.write_en2); end
    checks++; if (bus.write_data1 !== 32'hAAAA_0001 || bus.write_address1 !== 32'h8000_0004) begin errors++; $display("FAIL ri_w1 got %h/%h want aaaa0001/80000004", bus.write_data1, bus.write_address1); end
    checks++; if (bus.write_data2 !== 32'h0 || bus.write_address2 !== 32'h0) begin errors++; $display("FAIL ri_w2zero got %h/%h want 0/0", bus.write_data2, bus.write_address2); end
    cyc();
    idle_in();
    cyc();
    #1;
    checks++; if (bus.inst_addr !== 32'h8000_0008) begin errors++; $display("FAIL ri_next got %h want 80000008", bus.inst_addr); end
    grant(64'h7);
    #1;
    checks++; if (bus.write_en2 !== 1'b1 || bus.write_address1 !== 32'h8000_0008) begin errors++; $display("FAIL ri_w3 got %b %h want 1 80000008", bus.write_en2, bus.write_address1); end
    cyc();
    idle_in();
  endtask

  task automatic test_backpressure();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %b want 0", i, bus.inst_req); end
      cyc();
    end
    bus.fifo_full = 1'b0;
    #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL bp_rel got %b want 0", bus.inst_req); end
    cyc();
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0010) begin errors++; $display("FAIL bp_issue got %b %h want 1 80000010", bus.inst_req, bus.inst_addr); end
    grant(64'h9);
    #1;
    checks++; if (bus.write_address1 !== 32'h8000_0010) begin errors++; $display("FAIL bp_w got %h want 80000010", bus.write_address1); end
    cyc();
    idle_in();
  endtask

  task automatic test_redirect_wait();
    cyc();
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    #1;
    checks++; if (bus.fifo_flush !== 1'b1 || bus.write_en1 !== 1'b0) begin errors++; $display("FAIL rw_flush got %b/%b want 1/0", bus.fifo_flush, bus.write_en1); end
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++; if (bus.write_en1 !== 1'b0 || bus.write_en2 !== 1'b0) begin errors++; $display("FAIL rw_drop got %b%b want 00", bus.write_en1, bus.write_en2); end
    cyc();
    idle_in();
    #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rw_idle got %b want 0", bus.inst_req); end
    cyc();
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_1000) begin errors++; $display("FAIL rw_next got %b %h want 1 80001000", bus.inst_req, bus.inst_addr); end
    grant(64'h1);
    #1;
    checks++; if (bus.write_address1 !== 32'h8000_1000) begin errors++; $display("FAIL rw_w got %h want 80001000", bus.write_address1); end
    cyc();
    idle_in();
  endtask

  task automatic test_redirect_same_cycle();
    cyc();
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 64'h1234_5678_9ABC_DEF0;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h8000_2008;
    #1;
    checks++; if (bus.write_en1 !== 1'b0 || bus.write_en2 !== 1'b0) begin errors++; $display("FAIL rs_wen got %b%b want 00", bus.write_en1, bus.write_en2); end
    checks++; if (bus.fifo_flush !== 1'b1) begin errors++; $display("FAIL rs_flush got %b want 1", bus.fifo_flush); end
    cyc();
    idle_in();
    #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rs_idle got %b want 0", bus.inst_req); end
    cyc();
    #1;
    checks++; if (bus.inst_addr !== 32'h8000_2008) begin errors++; $display("FAIL rs_next got %h want 80002008", bus.inst_addr); end
    grant(64'h2);
    #1;
    checks++; if (bus.write_en2 !== 1'b1 || bus.write_address1 !== 32'h8000_2008) begin errors++; $display("FAIL rs_w got %b %h want 1 80002008", bus.write_en2, bus.write_address1); end
    cyc();
    idle_in();
  endtask

  task automatic test_redirect_req();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_2010) begin errors++; $display("FAIL rq_hold got %b %h want 1 80002010", bus.inst_req, bus.inst_addr); end
    cyc();
    redirect_valid = 1'b0;
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_2010) begin errors++; $display("FAIL rq_stable got %b %h want 1 80002010", bus.inst_req, bus.inst_addr); end
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 64'h3;
    #1;
    checks++; if (bus.write_en1 !== 1'b0) begin errors++; $display("FAIL rq_drop got %b want 0", bus.write_en1); end
    cyc();
    idle_in();
    cyc();
    #1;
    checks++; if (bus.inst_addr !== 32'h8000_3000) begin errors++; $display("FAIL rq_next got %h want 80003000", bus.inst_addr); end
    grant(64'h4);
    #1;
    checks++; if (bus.write_address1 !== 32'h8000_3000) begin errors++; $display("FAIL rq_w got %h want 80003000", bus.write_address1); end
    cyc();
    idle_in();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFB;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    #1;
    checks++; if (bus.inst_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req got %h want fffffff8", bus.inst_addr); end
    grant(64'h6);
    #1;
    checks++; if (bus.write_address1 !== 32'hFFFF_FFF8 || bus.write_address2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_w got %h/%h want fffffff8/fffffffc", bus.write_address1, bus.write_address2); end
    cyc();
    idle_in();
    cyc();
    #1;
    checks++; if (bus.inst_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", bus.inst_addr); end
    grant(64'h8);
    cyc();
    idle_in();
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.fifo_flush !== 1'b1 || bus.inst_req !== 1'b0) begin errors++; $display("FAIL rmw_rst got %b/%b want 1/0", bus.fifo_flush, bus.inst_req); end
    cyc();
    rst = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 64'hFACE_FACE_FACE_FACE;
    #1;
    checks++; if (bus.write_en1 !== 1'b0 || bus.write_en2 !== 1'b0 || bus.inst_req !== 1'b0) begin errors++; $display("FAIL rmw_late got %b%b req %b want 00 req 0", bus.write_en1, bus.write_en2, bus.inst_req); end
    cyc();
    idle_in();
    #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rmw_pc got %b %h want 1 bfc00000", bus.inst_req, bus.inst_addr); end
    grant(64'h0);
    cyc();
    idle_in();
  endtask

  task automatic test_random();
    logic [31:0] model_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_addr;
    logic        pend;
    logic        pend_live;
    logic        req_clean;
    logic        prev_req;
    logic        prev_full;
    logic        prev_redir;
    logic        prev_stall;
    logic        exp_w;
    int          dly;
    int          writes;
    rst = 1'b0;
    idle_in();
    bus.fifo_full = 1'b0;
    cyc();
    rst = 1'b1;
    model_pc = 32'hBFC0_0000;
    pend = 0; pend_live = 0; req_clean = 0; dly = 0;
    prev_req = 0; prev_full = 0; prev_redir = 0;
    prev_stall = 0; prev_addr = '0; pend_addr = '0;
    writes = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect_valid   = ($urandom_range(0, 15) == 0);
      redirect_pc      = $urandom();
      bus.fifo_full    = ($urandom_range(0, 3) == 0);
      bus.inst_addr_ok = !pend && ($urandom_range(0, 2) != 0);
      if (pend && dly == 0) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = {mem(pend_addr + 32'd4), mem(pend_addr)};
      end else begin
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = {$urandom(), $urandom()};
      end
      #1;
      exp_w = bus.inst_data_ok && pend_live && !redirect_valid;
      checks++; if (bus.fifo_flush !== redirect_valid) begin errors++; $display("FAIL rnd_flush c%0d got %b want %b", c, bus.fifo_flush, redirect_valid); end
      checks++; if (bus.write_en1 !== exp_w) begin errors++; $display("FAIL rnd_wen1 c%0d got %b want %b", c, bus.write_en1, exp_w); end
      if (exp_w) begin
        checks++; if (bus.write_address1 !== model_pc || bus.write_data1 !== mem(model_pc)) begin errors++; $display("FAIL rnd_w1 c%0d got %h/%h want %h/%h", c, bus.write_address1, bus.write_data1, model_pc, mem(model_pc)); end
        checks++; if (bus.write_en2 !== !model_pc[2]) begin errors++; $display("FAIL rnd_wen2 c%0d got %b want %b", c, bus.write_en2, !model_pc[2]); end
        if (!model_pc[2]) begin
          checks++; if (bus.write_address2 !== model_pc + 32'd4 || bus.write_data2 !== mem(model_pc + 32'd4)) begin errors++; $display("FAIL rnd_w2 c%0d got %h/%h want %h/%h", c, bus.write_address2, bus.write_data2, model_pc + 32'd4, mem(model_pc + 32'd4)); end
        end else begin
          checks++; if (bus.write_address2 !== 32'h0 || bus.write_data2 !== 32'h0) begin errors++; $display("FAIL rnd_w2zero c%0d got %h/%h want 0/0", c, bus.write_address2, bus.write_data2); end
        end
      end else begin
        checks++; if (bus.write_en2 !== 1'b0) begin errors++; $display("FAIL rnd_wen2x c%0d got %b want 0", c, bus.write_en2); end
      end
      if (bus.inst_req && !prev_req) begin
        checks++; if (prev_full || prev_redir) begin errors++; $display("FAIL rnd_issue c%0d full %b redir %b want 0/0", c, prev_full, prev_redir); end
        checks++; if (bus.inst_addr !== {model_pc[31:3], 3'b000}) begin errors++; $display("FAIL rnd_addr c%0d got %h want %h", c, bus.inst_addr, {model_pc[31:3], 3'b000}); end
        req_clean = 1'b1;
      end
      if (prev_stall) begin
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold c%0d got %b %h want 1 %h", c, bus.inst_req, bus.inst_addr, prev_addr); end
      end
      if (bus.inst_data_ok) pend = 1'b0;
      else if (pend) dly--;
      if (redirect_valid) begin
        req_clean = 1'b0;
        pend_live = 1'b0;
        model_pc  = {redirect_pc[31:2], 2'b00};
      end else if (exp_w) begin
        writes++;
        model_pc = model_pc + (model_pc[2] ? 32'd4 : 32'd8);
      end
      if (bus.inst_req && bus.inst_addr_ok) begin
        pend      = 1'b1;
        pend_addr = bus.inst_addr;
        pend_live = req_clean;
        dly       = $urandom_range(0, 3);
      end
      prev_stall = bus.inst_req && !bus.inst_addr_ok;
      prev_addr  = bus.inst_addr;
      prev_req   = bus.inst_req;
      prev_full  = bus.fifo_full;
      prev_redir = redirect_valid;
      cyc();
    end
    checks++; if (writes < 100) begin errors++; $display("FAIL rnd_progress got %0d writes want >=100", writes); end
    idle_in();
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.fifo_full    = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    test_reset();
    test_basic();
    test_redirect_idle();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_req();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
